// File: rtl/vram_arb_pkg.sv
// vram_arbiter shared types, default widths and helpers.
// Optional feature macro: VRAM_ARB_RR_EN (round-robin among 1..NREQ-1).
package vram_arb_pkg;

   localparam int NREQ_DEF         = 3;
   localparam int ADDR_WIDTH_DEF   = 15;
   localparam int DATA_WIDTH_DEF   = 13;
   localparam int STARVE_LIMIT_DEF = 64;
   localparam int NREQ_MAX         = 8;

   typedef logic [$clog2(NREQ_DEF)-1:0] arb_idx_t;

   function automatic logic [NREQ_MAX-1:0] onehot(
      input logic [2:0] idx
   );
      logic [NREQ_MAX-1:0] one;
      one = NREQ_MAX'(1);
      return one << idx;
   endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester/vram bundle for vram_arbiter.
// master = requesters + vram side, slave = arbiter.
interface vram_arbiter_if #(
   parameter int NREQ       = vram_arb_pkg::NREQ_DEF,
   parameter int ADDR_WIDTH = vram_arb_pkg::ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = vram_arb_pkg::DATA_WIDTH_DEF
) ();

   logic [NREQ-1:0]            req_valid;
   logic [NREQ*ADDR_WIDTH-1:0] req_addr;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]      rsp_data;
   logic                       vram_en;
   logic [ADDR_WIDTH-1:0]      vram_addr;
   logic [DATA_WIDTH-1:0]      vram_data;
   logic [NREQ-1:0]            starved;

   modport master (
      output req_valid,
      output req_addr,
      output vram_data,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  vram_en,
      input  vram_addr,
      input  starved
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  vram_data,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output vram_en,
      output vram_addr,
      output starved
   );

endinterface

// File: rtl/vram_arbiter_rr_pick.sv
// Rotate-priority encoder over indices 1..NREQ-1,
// searching upward from ptr and wrapping back to 1.
module rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         mask,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    found
);

   localparam int IW = $clog2(NREQ);

   always_comb begin
      int c;
      c     = 0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ - 1; k++) begin
         c = int'(ptr) + k;
         if (c >= NREQ) c = c - (NREQ - 1);
         if (!found && mask[c]) begin
            found = 1'b1;
            idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port vram read arbiter with fixed 1-cycle tagged response.
// Macro VRAM_ARB_RR_EN: round-robin among 1..NREQ-1 (else fixed priority).
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int NREQ         = NREQ_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input logic          clk,
   input logic          rst,
   vram_arbiter_if.slave bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef logic [IW-1:0] idx_t;

   idx_t pick_idx;
   logic pick_found;
   idx_t gnt_idx;
   logic gnt_any;
   logic tag_valid;
   idx_t tag_idx;

`ifdef VRAM_ARB_RR_EN
   idx_t rr_ptr;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .mask  (bus.req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= IW'(1);
      end else if (gnt_any && gnt_idx != '0) begin
         if (int'(gnt_idx) == NREQ - 1)
            rr_ptr <= IW'(1);
         else
            rr_ptr <= gnt_idx + IW'(1);
      end
   end
`else
   // Highest index first so the lowest valid index wins last.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      for (int i = NREQ - 1; i >= 1; i--) begin
         if (bus.req_valid[i]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(i);
         end
      end
   end
`endif

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (!rst) begin
         if (bus.req_valid[0]) begin
            gnt_any = 1'b1;
         end else if (pick_found) begin
            gnt_any = 1'b1;
            gnt_idx = pick_idx;
         end
      end
   end

   assign bus.req_ready = gnt_any
      ? NREQ'(onehot(3'(gnt_idx))) : '0;
   assign bus.vram_en   = gnt_any;
   assign bus.vram_addr = gnt_any
      ? bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]
      : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid <= 1'b0;
         tag_idx   <= '0;
      end else begin
         tag_valid <= gnt_any;
         tag_idx   <= gnt_idx;
      end
   end

   assign bus.rsp_valid = (tag_valid && !rst)
      ? NREQ'(onehot(3'(tag_idx))) : '0;
   assign bus.rsp_data  = bus.vram_data;

   assign bus.starved[0] = 1'b0;

   for (genvar i = 1; i < NREQ; i++) begin : g_starve
      logic [CW-1:0] cnt;
      logic          flag;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt  <= '0;
            flag <= 1'b0;
         end else if (!bus.req_valid[i] || bus.req_ready[i]) begin
            cnt <= '0;
         end else if (cnt != CW'(STARVE_LIMIT)) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(STARVE_LIMIT - 1)) flag <= 1'b1;
         end
      end

      assign bus.starved[i] = flag;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (NREQ=3, STARVE_LIMIT=4).
// Expected grant orders follow VRAM_ARB_RR_EN when it is defined.
module tb_vram_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 15;
   localparam int DW   = 13;
   localparam int SL   = 4;

   localparam logic [AW-1:0] A0 = 15'h0123;
   localparam logic [AW-1:0] A1 = 15'h0456;
   localparam logic [AW-1:0] A2 = 15'h0789;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   vram_arbiter_if #(
      .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) bus ();

   vram_arbiter #(
      .NREQ(NREQ), .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] vram_fn(
      input logic [AW-1:0] a
   );
      if (a == 15'h0123) return 13'h1ABC;
      return a[DW-1:0] ^ 13'h0A5A;
   endfunction

   function automatic logic [AW-1:0] addr_of(
      input logic [NREQ-1:0] oh
   );
      if (oh == 3'b001) return A0;
      if (oh == 3'b010) return A1;
      if (oh == 3'b100) return A2;
      return '0;
   endfunction

   // Behavioural vram: registered read, 1-cycle latency.
   always @(posedge clk)
      if (bus.vram_en) bus.vram_data <= vram_fn(bus.vram_addr);

   task automatic cyc(input logic [NREQ-1:0] v);
      @(negedge clk);
      bus.req_valid = v;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 3'b111;
      #1;
      checks++;
      if (bus.req_ready !== 3'b000) begin
         failures++;
         $display("FAIL rst_ready got=%b exp=000",
                  bus.req_ready);
      end
      checks++;
      if (bus.vram_en !== 1'b0) begin
         failures++;
         $display("FAIL rst_en got=%b exp=0", bus.vram_en);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (bus.vram_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_en c=%0d got=%b exp=0",
                     c, bus.vram_en);
         end
         checks++;
         if (bus.rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL idle_rsp c=%0d got=%b exp=000",
                     c, bus.rsp_valid);
         end
         checks++;
         if (bus.starved !== 3'b000) begin
            failures++;
            $display("FAIL idle_starved c=%0d got=%b exp=000",
                     c, bus.starved);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single();
      cyc(3'b001);
      checks++;
      if (bus.req_ready !== 3'b001) begin
         failures++;
         $display("FAIL single_ready got=%b exp=001",
                  bus.req_ready);
      end
      checks++;
      if (bus.vram_en !== 1'b1 || bus.vram_addr !== A0) begin
         failures++;
         $display("FAIL single_addr got=%b/%h exp=1/%h",
                  bus.vram_en, bus.vram_addr, A0);
      end
      cyc(3'b000);
      checks++;
      if (bus.rsp_valid !== 3'b001) begin
         failures++;
         $display("FAIL single_rsp got=%b exp=001",
                  bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_data !== 13'h1ABC) begin
         failures++;
         $display("FAIL single_data got=%h exp=1abc",
                  bus.rsp_data);
      end
      checks++;
      if (bus.vram_en !== 1'b0 || bus.vram_addr !== '0) begin
         failures++;
         $display("FAIL single_idle got=%b/%h exp=0/0",
                  bus.vram_en, bus.vram_addr);
      end
   endtask

   task automatic test_priority();
      logic [NREQ-1:0] exp;
      logic [NREQ-1:0] prev;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cyc(3'b111);
         checks++;
         if (bus.req_ready !== 3'b001
             || bus.vram_addr !== A0) begin
            failures++;
            $display("FAIL prio_zero c=%0d got=%b/%h exp=001/%h",
                     c, bus.req_ready, bus.vram_addr, A0);
         end
      end
      prev = 3'b001;
      for (int k = 0; k < 4; k++) begin
`ifdef VRAM_ARB_RR_EN
         exp = (k % 2 == 0) ? 3'b010 : 3'b100;
`else
         exp = 3'b010;
`endif
         cyc(3'b110);
         checks++;
         if (bus.req_ready !== exp) begin
            failures++;
            $display("FAIL prio_rr k=%0d got=%b exp=%b",
                     k, bus.req_ready, exp);
         end
         checks++;
         if (bus.rsp_valid !== prev) begin
            failures++;
            $display("FAIL prio_rsp k=%0d got=%b exp=%b",
                     k, bus.rsp_valid, prev);
         end
         prev = exp;
      end
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0] exp;
      logic [NREQ-1:0] prev;
      do_reset();
      prev = 3'b000;
      for (int k = 0; k < 5; k++) begin
`ifdef VRAM_ARB_RR_EN
         exp = (k % 2 == 0) ? 3'b010 : 3'b100;
`else
         exp = 3'b010;
`endif
         cyc(3'b110);
         checks++;
         if (bus.req_ready !== exp
             || bus.vram_addr !== addr_of(exp)) begin
            failures++;
            $display("FAIL b2b_grant k=%0d got=%b/%h exp=%b/%h",
                     k, bus.req_ready, bus.vram_addr,
                     exp, addr_of(exp));
         end
         checks++;
         if (bus.rsp_valid !== prev) begin
            failures++;
            $display("FAIL b2b_rsp k=%0d got=%b exp=%b",
                     k, bus.rsp_valid, prev);
         end
         if (prev != 3'b000) begin
            checks++;
            if (bus.rsp_data !== vram_fn(addr_of(prev))) begin
               failures++;
               $display("FAIL b2b_data k=%0d got=%h exp=%h",
                        k, bus.rsp_data,
                        vram_fn(addr_of(prev)));
            end
         end
         prev = exp;
      end
      cyc(3'b000);
      checks++;
      if (bus.rsp_valid !== prev) begin
         failures++;
         $display("FAIL b2b_tail got=%b exp=%b",
                  bus.rsp_valid, prev);
      end
   endtask

   task automatic test_starve();
      logic [NREQ-1:0] exp;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         exp = (c >= SL) ? 3'b010 : 3'b000;
         cyc(3'b011);
         checks++;
         if (bus.starved !== exp) begin
            failures++;
            $display("FAIL starve_set c=%0d got=%b exp=%b",
                     c, bus.starved, exp);
         end
      end
      for (int c = 0; c < 2; c++) begin
         cyc(3'b010);
         checks++;
         if (bus.starved !== 3'b010
             || bus.req_ready !== 3'b010) begin
            failures++;
            $display("FAIL starve_hold c=%0d got=%b/%b exp=010/010",
                     c, bus.starved, bus.req_ready);
         end
      end
      cyc(3'b000);
      checks++;
      if (bus.starved !== 3'b010) begin
         failures++;
         $display("FAIL starve_sticky got=%b exp=010",
                  bus.starved);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.starved !== 3'b000) begin
         failures++;
         $display("FAIL starve_clear got=%b exp=000",
                  bus.starved);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(3'b010);
      checks++;
      if (bus.req_ready !== 3'b010) begin
         failures++;
         $display("FAIL mid_pre got=%b exp=010",
                  bus.req_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 3'b100;
      #1;
      checks++;
      if (bus.req_ready !== 3'b000 || bus.vram_en !== 1'b0
          || bus.rsp_valid !== 3'b000) begin
         failures++;
         $display("FAIL mid_rst got=%b/%b/%b exp=000/0/000",
                  bus.req_ready, bus.vram_en, bus.rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 3'b110;
      #1;
      checks++;
      if (bus.rsp_valid !== 3'b000) begin
         failures++;
         $display("FAIL mid_rsp got=%b exp=000",
                  bus.rsp_valid);
      end
      checks++;
      if (bus.req_ready !== 3'b010) begin
         failures++;
         $display("FAIL mid_ptr got=%b exp=010",
                  bus.req_ready);
      end
      cyc(3'b000);
      checks++;
      if (bus.rsp_valid !== 3'b010) begin
         failures++;
         $display("FAIL mid_after got=%b exp=010",
                  bus.rsp_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = {A2, A1, A0};
      test_reset();
      test_single();
      test_priority();
      test_back_to_back();
      test_starve();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
